sc_io_regs: RTL and testbench
=============================

Name: sc_io_regs

Overview:
- Memory-mapped I/O register block between the single-cycle processor data bus and the board-I/O controller stage.
- Latches processor writes into HEX (16b) and LEDR (10b) output registers, which drive the controller's hex/ledr inputs.
- Synchronises and debounces raw KEY/SW board inputs.
- Exposes KEY/SW levels and sticky KEY press-edge flags for processor reads.

Parameters:
- DBITS, 32, data bus width.
- ABITS, 32, address bus width.
- IO_BASE, 32'hF0000000, base address of the register window.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a debounced bit changes (must be >= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  ABITS  byte address from processor.
- we  in  1  write strobe, one word per cycle.
- wdata  in  DBITS  write data.
- re  in  1  read strobe.
- rdata  out  DBITS  registered read data.
- rvalid  out  1  rdata valid; one-cycle pulse.
- key_raw  in  4  board KEY pins, active-low (0 = pressed).
- sw_raw  in  10  board switch pins.
- hex_out  out  16  to controller hex input; nibble n drives digit n.
- ledr_out  out  10  to controller ledr input.
- key_db  out  4  debounced KEY, active-low.
- sw_db  out  10  debounced SW.

Behaviour:
- Register map, offsets from IO_BASE. Word accesses only; addr[1:0] ignored.
  - 0x00 HEX: RW, bits[15:0].
  - 0x04 LEDR: RW, bits[9:0].
  - 0x10 KEYDATA: RO, bits[3:0] = ~key_db, so 1 = pressed.
  - 0x14 KEYEDGE: bits[3:0]; write-1-to-clear.
  - 0x20 SWDATA: RO, bits[9:0] = sw_db.
- Unused upper bits read 0. Writes to RO or unmapped offsets are ignored. Reads of unmapped offsets return 0.
- Writes: when we=1 and addr hits HEX/LEDR, the register updates at the clock edge; hex_out/ledr_out reflect it the next cycle (1-cycle latency).
- Reads: re=1 at cycle N gives rdata/rvalid at N+1.
  - rvalid=0 when re was 0. rdata holds its last value when not reading.
  - Read-after-write to the same register in consecutive cycles returns the new value.
  - If we and re are asserted in the same cycle, the write commits and the read returns the pre-write value.
- Input path, per bit:
  - 2-flop synchroniser.
  - Debounce counter of width clog2(DEBOUNCE_CYCLES+1). The counter increments while the synchronised value differs from the debounced value, and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced bit takes the synchronised value and the counter clears.
  - Total latency from stable raw change to db change = DEBOUNCE_CYCLES + 2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Edge capture:
  - KEYEDGE[i] sets on the cycle key_db[i] goes 1->0 (press). Release sets nothing.
  - A W1C write clears the selected bits.
  - If a new press and a W1C for the same bit occur in the same cycle, set wins.
- Reset, synchronous:
  - hex_out=0, ledr_out=0, rdata=0, rvalid=0, KEYEDGE=0.
  - key_db=4'hF (released), sw_db=0.
  - Synchroniser flops: key flops 1, sw flops 0.
  - All counters 0.
  - A reset asserted mid-debounce abandons the count. An in-flight read is dropped (rvalid=0 the next cycle).

Optional Feature:
- Macro: SC_IO_KEY_IRQ_EN.
- Defined:
  - Adds register KEYMASK at offset 0x18 (RW, bits[3:0], reset 0).
  - Adds output port irq (1b) = |(KEYEDGE & KEYMASK), registered, asserting the cycle after the edge/mask condition holds.
  - irq deasserts the cycle after the W1C clears the last masked flag.
- Not defined: no irq port; offset 0x18 reads 0 and writes are ignored.

Test Plan (DEBOUNCE_CYCLES=4 for bench):
- Reset check: hold reset 2 cycles -> hex_out=0, ledr_out=0, key_db=4'hF, sw_db=0, rvalid=0.
- Output write/readback:
  - Write 0x0000BEEF to IO_BASE+0x00, write 0x3FF to +0x04.
  - Then hex_out=16'hBEEF and ledr_out=10'h3FF next cycle.
  - Read +0x00 -> rdata=0x0000BEEF with rvalid one cycle later.
- Debounce:
  - Toggle sw_raw[0] to 1 for 3 cycles then back -> sw_db stays 0.
  - Hold sw_raw[0]=1 steadily -> sw_db[0]=1 exactly 6 cycles after the change; read +0x20 -> 0x001.
- Edge capture:
  - Drive key_raw[2]=0 for 10 cycles, release.
  - Read +0x14 -> 0x4; read +0x10 during the press -> 0x4.
  - Write 0x4 to +0x14 -> subsequent read returns 0.
- Set-vs-clear collision: arrange a key_db[1] press in the same cycle as a W1C of 0x2 -> KEYEDGE[1] remains 1.
- Unmapped/RO and IRQ:
  - Write 0xFFFFFFFF to +0x10 and +0x40 -> no state change; read +0x40 -> 0.
  - With SC_IO_KEY_IRQ_EN: set KEYMASK=0x1, press KEY0 -> irq=1; W1C 0x1 -> irq=0 next cycle.

Source files
------------

// File: rtl/sc_io_regs.sv
// Memory-mapped board I/O registers: HEX/LEDR outputs, synchronised and debounced KEY/SW inputs, sticky KEY press flags.
// Optional KEYMASK register and irq output are enabled by defining SC_IO_KEY_IRQ_EN.
module sc_io_regs #(
    parameter int               DBITS           = 32,
    parameter int               ABITS           = 32,
    parameter logic [ABITS-1:0] IO_BASE         = 32'hF0000000,
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ABITS-1:0] addr,
    input  logic             we,
    input  logic [DBITS-1:0] wdata,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             rvalid,
    input  logic [3:0]       key_raw,
    input  logic [9:0]       sw_raw,
    output logic [15:0]      hex_out,
    output logic [9:0]       ledr_out,
    output logic [3:0]       key_db,
    output logic [9:0]       sw_db
`ifdef SC_IO_KEY_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [13:0]     IN_RST   = {10'h000, 4'hF};
    localparam logic [ABITS-3:0] W_HEX     = (ABITS-2)'(0);
    localparam logic [ABITS-3:0] W_LEDR    = (ABITS-2)'(1);
    localparam logic [ABITS-3:0] W_KEYDATA = (ABITS-2)'(4);
    localparam logic [ABITS-3:0] W_KEYEDGE = (ABITS-2)'(5);
    localparam logic [ABITS-3:0] W_KEYMASK = (ABITS-2)'(6);
    localparam logic [ABITS-3:0] W_SWDATA  = (ABITS-2)'(8);

    logic [ABITS-1:0] off;
    logic [ABITS-3:0] widx;
    logic [15:0]      hex_q, hex_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [3:0]       edge_q, edge_d, key_press, edge_clr;
    logic [3:0]       mask_q, mask_d;
    logic [DBITS-1:0] rdata_q, rdata_d;
    logic             rvalid_q;
    logic [13:0]      raw_in, sync1_q, sync2_q, db_q, db_d;
    logic [CW-1:0]    cnt_q [14];
    logic [CW-1:0]    cnt_d [14];
    logic             unused_bits;

    assign off         = addr - IO_BASE;
    assign widx        = off[ABITS-1:2];
    assign raw_in      = {sw_raw, key_raw};
    assign unused_bits = ^{off[1:0], wdata[DBITS-1:16]};

    // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing synchronised samples.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 14; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) db_d[i] = sync2_q[i];
                else                      cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A press landing on the same edge as its W1C wins, because the set is OR-ed in last.
    always_comb begin
        key_press = db_q[3:0] & ~db_d[3:0];
        edge_clr  = (we && widx == W_KEYEDGE) ? wdata[3:0] : 4'h0;
        edge_d    = (edge_q & ~edge_clr) | key_press;
        hex_d     = (we && widx == W_HEX)  ? wdata[15:0] : hex_q;
        ledr_d    = (we && widx == W_LEDR) ? wdata[9:0]  : ledr_q;
`ifdef SC_IO_KEY_IRQ_EN
        mask_d    = (we && widx == W_KEYMASK) ? wdata[3:0] : mask_q;
`else
        mask_d    = 4'h0;
`endif
    end

    // Read mux sees pre-write register values, so a simultaneous write is not visible yet.
    always_comb begin
        rdata_d = '0;
        case (widx)
            W_HEX:     rdata_d[15:0] = hex_q;
            W_LEDR:    rdata_d[9:0]  = ledr_q;
            W_KEYDATA: rdata_d[3:0]  = ~db_q[3:0];
            W_KEYEDGE: rdata_d[3:0]  = edge_q;
            W_KEYMASK: rdata_d[3:0]  = mask_q;
            W_SWDATA:  rdata_d[9:0]  = db_q[13:4];
            default:   rdata_d       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q    <= '0;
            ledr_q   <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            sync1_q  <= IN_RST;
            sync2_q  <= IN_RST;
            db_q     <= IN_RST;
            for (int i = 0; i < 14; i++) cnt_q[i] <= '0;
        end else begin
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            if (re) rdata_q <= rdata_d;
            rvalid_q <= re;
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            for (int i = 0; i < 14; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef SC_IO_KEY_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |(edge_q & mask_q);
    end
    assign irq = irq_q;
`endif

    assign hex_out  = hex_q;
    assign ledr_out = ledr_q;
    assign key_db   = db_q[3:0];
    assign sw_db    = db_q[13:4];
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_sc_io_regs.sv
// Directed bench for sc_io_regs with a window-based behavioural model checked every cycle.
// Define SC_IO_KEY_IRQ_EN to also exercise KEYMASK and irq.
module tb_sc_io_regs;

    localparam int          D      = 4;
    localparam logic [31:0] BASE   = 32'hF0000000;
    localparam logic [13:0] IN_RST = {10'h000, 4'hF};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        we, re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  key_raw;
    logic [9:0]  sw_raw;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [3:0]  key_db;
    logic [9:0]  sw_db;
`ifdef SC_IO_KEY_IRQ_EN
    logic        irq;
`endif

    sc_io_regs #(.DBITS(32), .ABITS(32), .IO_BASE(BASE), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .re(re),
        .rdata(rdata), .rvalid(rvalid), .key_raw(key_raw), .sw_raw(sw_raw),
        .hex_out(hex_out), .ledr_out(ledr_out), .key_db(key_db), .sw_db(sw_db)
`ifdef SC_IO_KEY_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model state: registers plus the last D+1 raw input samples.
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [3:0]  m_edge, m_mask, m_press, m_clr;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_irq, m_all_diff;
    logic [13:0] m_db, m_db_new;
    logic [13:0] hist [0:D];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) & ~32'h3;
        case (o)
            32'h00:  return {16'h0, m_hex};
            32'h04:  return {22'h0, m_ledr};
            32'h10:  return {28'h0, ~m_db[3:0]};
            32'h14:  return {28'h0, m_edge};
`ifdef SC_IO_KEY_IRQ_EN
            32'h18:  return {28'h0, m_mask};
`endif
            32'h20:  return {22'h0, m_db[13:4]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit hits(input logic [31:0] a, input logic [31:0] o);
        return ((a - BASE) & ~32'h3) == o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hex = '0; m_ledr = '0; m_edge = '0; m_mask = '0;
            m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0; m_db = IN_RST;
            for (int j = 0; j <= D; j++) hist[j] = IN_RST;
        end else begin
            if (re) m_rdata = m_read(addr);
            m_rvalid = re;
            m_irq    = |(m_edge & m_mask);
            // A bit flips once the D synchronised samples (raw delayed by 2) all disagree with it.
            m_db_new = m_db;
            for (int b = 0; b < 14; b++) begin
                m_all_diff = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[j][b] == m_db[b]) m_all_diff = 1'b0;
                if (m_all_diff) m_db_new[b] = ~m_db[b];
            end
            m_press = m_db[3:0] & ~m_db_new[3:0];
            m_clr   = (we && hits(addr, 32'h14)) ? wdata[3:0] : 4'h0;
            m_edge  = (m_edge & ~m_clr) | m_press;
            if (we && hits(addr, 32'h00)) m_hex  = wdata[15:0];
            if (we && hits(addr, 32'h04)) m_ledr = wdata[9:0];
`ifdef SC_IO_KEY_IRQ_EN
            if (we && hits(addr, 32'h18)) m_mask = wdata[3:0];
`endif
            m_db = m_db_new;
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = {sw_raw, key_raw};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("hex_out",  {16'h0, hex_out},  {16'h0, m_hex});
            chk("ledr_out", {22'h0, ledr_out}, {22'h0, m_ledr});
            chk("key_db",   {28'h0, key_db},   {28'h0, m_db[3:0]});
            chk("sw_db",    {22'h0, sw_db},    {22'h0, m_db[13:4]});
            chk("rvalid",   {31'h0, rvalid},   {31'h0, m_rvalid});
            chk("rdata",    rdata,             m_rdata);
`ifdef SC_IO_KEY_IRQ_EN
            chk("irq",      {31'h0, irq},      {31'h0, m_irq});
`endif
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        addr = BASE + off; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [31:0] off, input logic [31:0] exp);
        addr = BASE + off; re = 1'b1;
        tick();
        re = 1'b0;
        chk({name, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        chk(name, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        key_raw = 4'hF; sw_raw = '0;
        tick(2);
        started = 1'b1;
        chk("rst_hex",    {16'h0, hex_out},  32'h0);
        chk("rst_ledr",   {22'h0, ledr_out}, 32'h0);
        chk("rst_key_db", {28'h0, key_db},   32'hF);
        chk("rst_sw_db",  {22'h0, sw_db},    32'h0);
        chk("rst_rvalid", {31'h0, rvalid},   32'h0);
        reset = 1'b0;

        wr(32'h00, 32'h0000BEEF);
        chk("hex_beef", {16'h0, hex_out}, 32'hBEEF);
        wr(32'h04, 32'h000003FF);
        chk("ledr_3ff", {22'h0, ledr_out}, 32'h3FF);
        rd_expect("rd_hex", 32'h00, 32'h0000BEEF);
        tick();
        chk("rvalid_drop", {31'h0, rvalid}, 32'h0);

        // Same-cycle write and read returns the old value; the next read sees the new one.
        addr = BASE; wdata = 32'h1234; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("wr_rd_same", rdata, 32'h0000BEEF);
        rd_expect("rd_after_wr", 32'h00, 32'h00001234);

        wr(32'h10, 32'hFFFFFFFF);
        wr(32'h40, 32'hFFFFFFFF);
        chk("ro_hex_kept", {16'h0, hex_out}, 32'h1234);
        rd_expect("rd_unmapped", 32'h40, 32'h0);
        rd_expect("rd_keyedge0", 32'h14, 32'h0);

        sw_raw[0] = 1'b1;
        tick(3);
        sw_raw[0] = 1'b0;
        tick(8);
        chk("glitch_sw", {22'h0, sw_db}, 32'h0);

        sw_raw[0] = 1'b1;
        tick(5);
        chk("sw_at_5", {22'h0, sw_db}, 32'h0);
        tick();
        chk("sw_at_6", {22'h0, sw_db}, 32'h1);
        rd_expect("rd_sw", 32'h20, 32'h1);

        key_raw[2] = 1'b0;
        tick(7);
        rd_expect("rd_keydata", 32'h10, 32'h4);
        tick(2);
        key_raw = 4'hF;
        tick(8);
        rd_expect("rd_keyedge", 32'h14, 32'h4);
        wr(32'h14, 32'h4);
        rd_expect("rd_keyedge_clr", 32'h14, 32'h0);

        // W1C of bit 1 lands on the same edge key_db[1] falls.
        key_raw[1] = 1'b0;
        tick(5);
        wr(32'h14, 32'h2);
        rd_expect("collision", 32'h14, 32'h2);
        key_raw = 4'hF;
        tick(8);
        wr(32'h14, 32'h2);

`ifdef SC_IO_KEY_IRQ_EN
        wr(32'h18, 32'h1);
        key_raw[0] = 1'b0;
        tick(7);
        chk("irq_set", {31'h0, irq}, 32'h1);
        key_raw = 4'hF;
        tick(8);
        wr(32'h14, 32'h1);
        tick();
        chk("irq_clr", {31'h0, irq}, 32'h0);
`endif

        sw_raw[1] = 1'b1;
        tick(3);
        reset = 1'b1; re = 1'b1; addr = BASE;
        tick();
        reset = 1'b0; re = 1'b0;
        chk("rst_mid_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_mid_sw",     {22'h0, sw_db},  32'h0);
        chk("rst_mid_hex",    {16'h0, hex_out}, 32'h0);
        tick(6);
        chk("sw_after_rst", {22'h0, sw_db}, 32'h3);
        rd_expect("rd_hex_rst", 32'h00, 32'h0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
